// File: rtl/record_deserializer_if.sv
// Record-path bus between the recorder controller / ADC side and the
// record_deserializer: control inputs, serial link and clip-memory write port.
interface record_deserializer_if #(
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned SAMPLE_W = 8
) ();
    logic                enableDes;
    logic [ADDR_W-1:0]   startAddress;
    logic                serialIn;
    logic                bitClkOut;
    logic                memWe;
    logic [ADDR_W-1:0]   memAddr;
    logic [SAMPLE_W-1:0] memData;
    logic [15:0]         sampleCount;
    logic                busy;
    logic                clipFull;

    // Controller / ADC / memory side
    modport master (
        output enableDes,
        output startAddress,
        output serialIn,
        input  bitClkOut,
        input  memWe,
        input  memAddr,
        input  memData,
        input  sampleCount,
        input  busy,
        input  clipFull
    );

    // Deserializer side
    modport slave (
        input  enableDes,
        input  startAddress,
        input  serialIn,
        output bitClkOut,
        output memWe,
        output memAddr,
        output memData,
        output sampleCount,
        output busy,
        output clipFull
    );
endinterface

// File: rtl/record_deserializer.sv
// record_deserializer: generates the ADC bit clock, shifts serial samples in
// MSB first and writes each assembled sample to consecutive clip-memory
// addresses while enableDes is held high.
// Optional feature macro: REC_CLIP_LIMIT_EN -- stop writing after
// CLIP_SAMPLES samples and park in HOLD with a sticky clipFull flag.
// All outputs are registered; they are computed from the next state so that
// they line up with the state they belong to.
module record_deserializer #(
    parameter int unsigned SAMPLE_W     = 8,
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned CLIP_SAMPLES = 8000
) (
    input  logic                  clock,
    input  logic                  ResetB,
    record_deserializer_if.slave  bus
);

    localparam int unsigned DCW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BCW = (SAMPLE_W > 2) ? $clog2(SAMPLE_W) : 1;
    localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
    localparam logic [DCW-1:0] DIV_HALF = DCW'(CLK_DIV / 2);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(SAMPLE_W - 1);

`ifdef REC_CLIP_LIMIT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        WRITE = 3'd3
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DCW-1:0]      div_cnt_q, div_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         sample_count_q, sample_count_d;
    logic                clip_full_q, clip_full_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [SAMPLE_W-1:0] mem_data_q, mem_data_d;
    logic                bit_clk_q, bit_clk_d;
    logic                busy_q, busy_d;

    // Next-state and datapath logic: divider, bit counter, shifter, address.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        div_cnt_d      = div_cnt_q;
        addr_d         = addr_q;
        sample_count_d = sample_count_q;
        clip_full_d    = clip_full_q;
        case (state_q)
            IDLE: begin
                if (bus.enableDes) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                addr_d         = bus.startAddress;
                shift_d        = {SAMPLE_W{1'b0}};
                bit_cnt_d      = {BCW{1'b0}};
                div_cnt_d      = {DCW{1'b0}};
                sample_count_d = 16'h0000;
                clip_full_d    = 1'b0;
                state_d        = SHIFT;
            end
            SHIFT: begin
                if (!bus.enableDes) begin
                    // Abort: the partial sample is thrown away.
                    state_d   = IDLE;
                    shift_d   = {SAMPLE_W{1'b0}};
                    bit_cnt_d = {BCW{1'b0}};
                    div_cnt_d = {DCW{1'b0}};
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = {DCW{1'b0}};
                    shift_d   = {shift_q[SAMPLE_W-2:0], bus.serialIn};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = {BCW{1'b0}};
                        state_d   = WRITE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DCW'(1);
                end
            end
            WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                if (sample_count_q != 16'hFFFF) begin
                    sample_count_d = sample_count_q + 16'd1;
                end else begin
                    sample_count_d = sample_count_q;
                end
`ifdef REC_CLIP_LIMIT_EN
                if (sample_count_d == 16'(CLIP_SAMPLES)) begin
                    state_d     = HOLD;
                    clip_full_d = 1'b1;
                end else if (bus.enableDes) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
`else
                if (bus.enableDes) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
`endif
            end
`ifdef REC_CLIP_LIMIT_EN
            HOLD: begin
                if (!bus.enableDes) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic, evaluated on the next state so the registered outputs
    // are valid during the cycle of the state they describe.
    always_comb begin
        mem_we_d   = 1'b0;
        mem_addr_d = {ADDR_W{1'b0}};
        mem_data_d = {SAMPLE_W{1'b0}};
        bit_clk_d  = 1'b0;
        busy_d     = (state_d != IDLE);
        if (state_d == WRITE) begin
            mem_we_d   = 1'b1;
            mem_addr_d = addr_d;
            mem_data_d = shift_d;
        end else begin
            mem_we_d = 1'b0;
        end
        if (state_d == SHIFT) begin
            bit_clk_d = (div_cnt_d < DIV_HALF);
        end else begin
            bit_clk_d = 1'b0;
        end
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge ResetB) begin
        if (!ResetB) begin
            state_q        <= IDLE;
            shift_q        <= {SAMPLE_W{1'b0}};
            bit_cnt_q      <= {BCW{1'b0}};
            div_cnt_q      <= {DCW{1'b0}};
            addr_q         <= {ADDR_W{1'b0}};
            sample_count_q <= 16'h0000;
            clip_full_q    <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= {ADDR_W{1'b0}};
            mem_data_q     <= {SAMPLE_W{1'b0}};
            bit_clk_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            div_cnt_q      <= div_cnt_d;
            addr_q         <= addr_d;
            sample_count_q <= sample_count_d;
            clip_full_q    <= clip_full_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            bit_clk_q      <= bit_clk_d;
            busy_q         <= busy_d;
        end
    end

`ifdef REC_CLIP_LIMIT_EN
    assign bus.clipFull = clip_full_q;
`else
    // Without the clip limit the flag register never sets; the limit value
    // is only referenced so the parameter list is identical in both builds.
    logic [15:0] unused_clip_limit_s;
    assign unused_clip_limit_s = 16'(CLIP_SAMPLES) ^ {15'd0, clip_full_q};
    assign bus.clipFull = 1'b0;
`endif

    assign bus.bitClkOut   = bit_clk_q;
    assign bus.memWe       = mem_we_q;
    assign bus.memAddr     = mem_addr_q;
    assign bus.memData     = mem_data_q;
    assign bus.sampleCount = sample_count_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_record_deserializer.sv
// Directed self-checking bench for record_deserializer (CLK_DIV=4, SAMPLE_W=8).
module tb_record_deserializer;

`ifdef REC_CLIP_LIMIT_EN
    localparam int unsigned TB_CLIP = 3;
`else
    localparam int unsigned TB_CLIP = 8000;
`endif

    logic clock;
    logic ResetB;
    int   checks;
    int   errors;

    record_deserializer_if #(.ADDR_W(17), .SAMPLE_W(8)) bus ();

    record_deserializer #(
        .SAMPLE_W    (8),
        .ADDR_W      (17),
        .CLK_DIV     (4),
        .CLIP_SAMPLES(TB_CLIP)
    ) dut (
        .clock (clock),
        .ResetB(ResetB),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives ncyc SHIFT cycles of sample d (MSB first, 4 cycles per bit),
    // checking the bit clock pattern and absence of writes on every cycle.
    task automatic shift_cycles(input logic [7:0] d, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            bus.serialIn = d[7 - (k / 4)];
            chk("bitclk", {31'd0, bus.bitClkOut}, ((k % 4) < 2) ? 32'd1 : 32'd0);
            chk("we_in_shift", {31'd0, bus.memWe}, 32'd0);
            chk("busy_shift", {31'd0, bus.busy}, 32'd1);
            step();
        end
    endtask

    task automatic chk_write(input string tag, input logic [16:0] a, input logic [7:0] d);
        chk({tag, "_we"}, {31'd0, bus.memWe}, 32'd1);
        chk({tag, "_addr"}, {15'd0, bus.memAddr}, {15'd0, a});
        chk({tag, "_data"}, {24'd0, bus.memData}, {24'd0, d});
        chk({tag, "_bitclk"}, {31'd0, bus.bitClkOut}, 32'd0);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        ResetB           = 1'b0;
        bus.enableDes    = 1'b0;
        bus.startAddress = 17'h00000;
        bus.serialIn     = 1'b0;

        // Reset state, before any clock edge
        #2;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_we", {31'd0, bus.memWe}, 32'd0);
        chk("rst_bitclk", {31'd0, bus.bitClkOut}, 32'd0);
        chk("rst_addr", {15'd0, bus.memAddr}, 32'd0);
        chk("rst_data", {24'd0, bus.memData}, 32'd0);
        chk("rst_count", {16'd0, bus.sampleCount}, 32'd0);
        chk("rst_clip", {31'd0, bus.clipFull}, 32'd0);
        step();
        step();
        ResetB = 1'b1;
        step();
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);

        // Test 1/2: single sample then continuous run
        bus.startAddress = 17'h00100;
        bus.enableDes    = 1'b1;
        step();                                   // cycle 1: LOAD
        chk("load_busy", {31'd0, bus.busy}, 32'd1);
        chk("load_we", {31'd0, bus.memWe}, 32'd0);
        chk("load_bitclk", {31'd0, bus.bitClkOut}, 32'd0);
        step();                                   // cycle 2: SHIFT
        shift_cycles(8'hA5, 32);                  // cycles 2..33
        chk_write("w1", 17'h00100, 8'hA5);        // cycle 34
        chk("w1_count_before", {16'd0, bus.sampleCount}, 32'd0);
        step();                                   // cycle 35
        chk("w1_count", {16'd0, bus.sampleCount}, 32'd1);
        shift_cycles(8'h3C, 32);                  // cycles 35..66
        chk_write("w2", 17'h00101, 8'h3C);        // cycle 67
        step();
        chk("w2_count", {16'd0, bus.sampleCount}, 32'd2);
        chk("w2_we_off", {31'd0, bus.memWe}, 32'd0);
        chk("w2_clip", {31'd0, bus.clipFull}, 32'd0);
        bus.enableDes = 1'b0;
        step();
        chk("stop_busy", {31'd0, bus.busy}, 32'd0);

        // Test 3: address wrap
        bus.startAddress = 17'h1FFFF;
        bus.enableDes    = 1'b1;
        step();
        step();
        shift_cycles(8'h5A, 32);
        chk_write("wrap1", 17'h1FFFF, 8'h5A);
        step();
        shift_cycles(8'hC3, 32);
        chk_write("wrap2", 17'h00000, 8'hC3);
        step();
        bus.enableDes = 1'b0;
        step();
        chk("wrap_idle", {31'd0, bus.busy}, 32'd0);

        // Test 4: abort after 5 bits, then restart at startAddress
        bus.startAddress = 17'h00200;
        bus.enableDes    = 1'b1;
        step();
        step();
        shift_cycles(8'hFF, 20);
        bus.enableDes = 1'b0;
        step();
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_we", {31'd0, bus.memWe}, 32'd0);
        chk("abort_bitclk", {31'd0, bus.bitClkOut}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            chk("abort_idle_we", {31'd0, bus.memWe}, 32'd0);
            step();
        end
        bus.startAddress = 17'h00300;
        bus.enableDes    = 1'b1;
        step();
        step();
        shift_cycles(8'h81, 32);
        chk_write("restart", 17'h00300, 8'h81);
        step();
        bus.enableDes = 1'b0;
        step();

        // Test 5: asynchronous reset mid-SHIFT
        bus.enableDes = 1'b1;
        step();
        step();
        shift_cycles(8'hF0, 8);
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        chk("pre_rst_bitclk", {31'd0, bus.bitClkOut}, 32'd1);
        #2;
        ResetB = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_bitclk", {31'd0, bus.bitClkOut}, 32'd0);
        chk("arst_we", {31'd0, bus.memWe}, 32'd0);
        bus.enableDes = 1'b0;
        step();
        ResetB = 1'b1;
        step();
        step();
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("post_rst_we", {31'd0, bus.memWe}, 32'd0);

`ifdef REC_CLIP_LIMIT_EN
        // Test 6: clip limit of 3 samples
        bus.startAddress = 17'h00040;
        bus.enableDes    = 1'b1;
        step();
        step();
        shift_cycles(8'h11, 32);
        chk_write("clip_w1", 17'h00040, 8'h11);
        step();
        shift_cycles(8'h22, 32);
        chk_write("clip_w2", 17'h00041, 8'h22);
        step();
        shift_cycles(8'h33, 32);
        chk_write("clip_w3", 17'h00042, 8'h33);
        chk("clip_before", {31'd0, bus.clipFull}, 32'd0);
        step();
        chk("clip_set", {31'd0, bus.clipFull}, 32'd1);
        chk("clip_count", {16'd0, bus.sampleCount}, 32'd3);
        for (int i = 0; i < 40; i++) begin
            chk("hold_we", {31'd0, bus.memWe}, 32'd0);
            chk("hold_bitclk", {31'd0, bus.bitClkOut}, 32'd0);
            chk("hold_busy", {31'd0, bus.busy}, 32'd1);
            step();
        end
        bus.enableDes = 1'b0;
        step();
        chk("hold_exit_busy", {31'd0, bus.busy}, 32'd0);
        chk("hold_exit_clip", {31'd0, bus.clipFull}, 32'd1);
        bus.enableDes = 1'b1;
        step();
        chk("reload_clip_in_load", {31'd0, bus.clipFull}, 32'd1);
        step();
        chk("reload_clip_cleared", {31'd0, bus.clipFull}, 32'd0);
        bus.enableDes = 1'b0;
        step();
`else
        chk("noclip_flag", {31'd0, bus.clipFull}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
